writeback_stage: RTL and testbench

- Final pipeline stage. Consumes memory-stage results (ALU value, load data, control) and produces the register-file write port: data, destination, enable.
- Registers the MEM/WB boundary and performs load sign/zero extension with byte/halfword lane selection.
- Issues exactly one register write per retired instruction, including across stalls.

---
 rtl/writeback_stage_pkg.sv | 25 ++
 rtl/writeback_stage_load_extend.sv | 35 +++
 rtl/writeback_stage.sv | 142 ++++++++++++++
 tb/tb_writeback_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: opcode widths, load opcodes, offset width.
`ifndef WRITEBACK_STAGE_DEFINES
`define WRITEBACK_STAGE_DEFINES
`define OPCODE_WIDTH 6
`define FUNCT_WIDTH 6
`endif

package writeback_stage_pkg;

  localparam int unsigned OPCODE_W = `OPCODE_WIDTH;
  localparam int unsigned OFF_W    = 2;
  localparam int unsigned RET_W    = 32;

  localparam logic [OPCODE_W-1:0] OP_LB  = OPCODE_W'(8'h20);
  localparam logic [OPCODE_W-1:0] OP_LH  = OPCODE_W'(8'h21);
  localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(8'h23);
  localparam logic [OPCODE_W-1:0] OP_LBU = OPCODE_W'(8'h24);
  localparam logic [OPCODE_W-1:0] OP_LHU = OPCODE_W'(8'h25);

  // True for the halfword loads, which need 2-byte alignment.
  function automatic logic is_half_load(input logic [OPCODE_W-1:0] op);
    return (op == OP_LH) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Load lane selection (little-endian) plus sign/zero extension.
module writeback_stage_load_extend
  import writeback_stage_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic [OPCODE_W-1:0] le_i_opcode,
  input  logic [OFF_W-1:0]    le_i_offset,
  input  logic [DWIDTH-1:0]   le_i_word,
  output logic [DWIDTH-1:0]   le_o_data
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  // Pick the addressed lane, then extend according to the load opcode.
  always_comb begin
    half_v = le_i_offset[1] ? le_i_word[31:16] : le_i_word[15:0];
    case (le_i_offset)
      2'd0:    byte_v = le_i_word[7:0];
      2'd1:    byte_v = le_i_word[15:8];
      2'd2:    byte_v = le_i_word[23:16];
      default: byte_v = le_i_word[31:24];
    endcase
    le_o_data = le_i_word;
    case (le_i_opcode)
      OP_LB:   le_o_data = {{(DWIDTH-8){byte_v[7]}}, byte_v};
      OP_LBU:  le_o_data = {{(DWIDTH-8){1'b0}}, byte_v};
      OP_LH:   le_o_data = {{(DWIDTH-16){half_v[15]}}, half_v};
      OP_LHU:  le_o_data = {{(DWIDTH-16){1'b0}}, half_v};
      default: le_o_data = le_i_word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and register-file write port.
// Optional retirement counter output wb_o_retired is enabled by WB_RETIRE_CNT_EN.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 5
) (
  input  logic                wb_clk,
  input  logic                wb_rst,
  input  logic                wb_i_ce,
  input  logic                wb_i_stall,
  input  logic                wb_i_flush,
  input  logic [DWIDTH-1:0]   wb_i_alu_value,
  input  logic [DWIDTH-1:0]   wb_i_load_data,
  input  logic                wb_i_memtoreg,
  input  logic                wb_i_reg_wr,
  input  logic [AWIDTH-1:0]   wb_i_rd_addr,
  input  logic [OPCODE_W-1:0] wb_i_opcode,
  output logic                wb_o_ce,
  output logic                wb_o_reg_wr,
  output logic [AWIDTH-1:0]   wb_o_rd_addr,
  output logic [DWIDTH-1:0]   wb_o_data,
`ifdef WB_RETIRE_CNT_EN
  output logic [RET_W-1:0]    wb_o_retired,
`endif
  output logic                wb_o_misalign
);

  logic                ce_q, ce_d;
  logic [DWIDTH-1:0]   alu_q, alu_d;
  logic [DWIDTH-1:0]   load_q, load_d;
  logic                memtoreg_q, memtoreg_d;
  logic                reg_wr_q, reg_wr_d;
  logic [AWIDTH-1:0]   rd_q, rd_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                written_q, written_d;
  logic                mis_written_q, mis_written_d;
  logic [RET_W-1:0]    retired_q, retired_d;

  logic [OFF_W-1:0]    off_c;
  logic [DWIDTH-1:0]   load_ext_c;
  logic                misaligned_c;
  logic                reg_wr_c;
  logic                misalign_c;

  assign off_c = alu_q[OFF_W-1:0];

  writeback_stage_load_extend #(.DWIDTH(DWIDTH)) u_load_extend (
    .le_i_opcode (op_q),
    .le_i_offset (off_c),
    .le_i_word   (load_q),
    .le_o_data   (load_ext_c)
  );

  // Write-port decode from held state; flags make each event fire once per instruction.
  always_comb begin
    misaligned_c = memtoreg_q & ce_q &
                   (((op_q == OP_LW) & (off_c != '0)) | (is_half_load(op_q) & off_c[0]));
    reg_wr_c     = ce_q & reg_wr_q & (rd_q != '0) & ~written_q & ~misaligned_c;
    misalign_c   = misaligned_c & ~mis_written_q;
  end

  // Next-state: flush beats stall, stall holds, otherwise capture.
  always_comb begin
    ce_d          = ce_q;
    alu_d         = alu_q;
    load_d        = load_q;
    memtoreg_d    = memtoreg_q;
    reg_wr_d      = reg_wr_q;
    rd_d          = rd_q;
    op_d          = op_q;
    written_d     = written_q;
    mis_written_d = mis_written_q;
    retired_d     = retired_q;
    if (ce_q && !wb_i_stall && !wb_i_flush) begin
      retired_d = retired_q + RET_W'(1);
    end
    if (wb_i_flush) begin
      ce_d          = 1'b0;
      written_d     = 1'b0;
      mis_written_d = 1'b0;
    end else if (!wb_i_stall) begin
      ce_d          = wb_i_ce;
      alu_d         = wb_i_alu_value;
      load_d        = wb_i_load_data;
      memtoreg_d    = wb_i_memtoreg;
      reg_wr_d      = wb_i_reg_wr;
      rd_d          = wb_i_rd_addr;
      op_d          = wb_i_opcode;
      written_d     = 1'b0;
      mis_written_d = 1'b0;
    end else begin
      written_d     = written_q | reg_wr_c;
      mis_written_d = mis_written_q | misalign_c;
    end
  end

  // Stage registers with asynchronous reset.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      ce_q          <= 1'b0;
      alu_q         <= '0;
      load_q        <= '0;
      memtoreg_q    <= 1'b0;
      reg_wr_q      <= 1'b0;
      rd_q          <= '0;
      op_q          <= '0;
      written_q     <= 1'b0;
      mis_written_q <= 1'b0;
      retired_q     <= '0;
    end else begin
      ce_q          <= ce_d;
      alu_q         <= alu_d;
      load_q        <= load_d;
      memtoreg_q    <= memtoreg_d;
      reg_wr_q      <= reg_wr_d;
      rd_q          <= rd_d;
      op_q          <= op_d;
      written_q     <= written_d;
      mis_written_q <= mis_written_d;
      retired_q     <= retired_d;
    end
  end

  // Output drive.
  always_comb begin
    wb_o_ce       = ce_q;
    wb_o_reg_wr   = reg_wr_c;
    wb_o_rd_addr  = rd_q;
    wb_o_data     = memtoreg_q ? load_ext_c : alu_q;
    wb_o_misalign = misalign_c;
  end

`ifdef WB_RETIRE_CNT_EN
  assign wb_o_retired = retired_q;
`else
  logic unused_retired_c;
  assign unused_retired_c = ^retired_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed test-plan cases plus random traffic.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  localparam int unsigned OW = OPCODE_W;

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic          ce, stall, flush, mtr, rw;
  logic [31:0]   alu, ld;
  logic [4:0]    rd;
  logic [OW-1:0] op;

  logic          o_ce, o_wr, o_mis;
  logic [4:0]    o_rd;
  logic [31:0]   o_data;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0]   o_ret;
`endif

  int total  = 0;
  int passed = 0;

  writeback_stage #(.DWIDTH(32), .AWIDTH(5)) dut (
    .wb_clk         (wb_clk),
    .wb_rst         (wb_rst),
    .wb_i_ce        (ce),
    .wb_i_stall     (stall),
    .wb_i_flush     (flush),
    .wb_i_alu_value (alu),
    .wb_i_load_data (ld),
    .wb_i_memtoreg  (mtr),
    .wb_i_reg_wr    (rw),
    .wb_i_rd_addr   (rd),
    .wb_i_opcode    (op),
    .wb_o_ce        (o_ce),
    .wb_o_reg_wr    (o_wr),
    .wb_o_rd_addr   (o_rd),
    .wb_o_data      (o_data),
`ifdef WB_RETIRE_CNT_EN
    .wb_o_retired   (o_ret),
`endif
    .wb_o_misalign  (o_mis)
  );

  always #5 wb_clk = ~wb_clk;

  // Reference model: the instruction currently held and whether its write/misalign already fired.
  logic          m_ce, m_mtr, m_rw;
  logic [31:0]   m_alu, m_ld;
  logic [4:0]    m_rd;
  logic [OW-1:0] m_op;
  bit            m_wr_done, m_mis_done;
  logic [31:0]   m_ret;

  function automatic logic [31:0] exp_data();
    logic [31:0] b, h;
    int unsigned off;
    off = int'(m_alu[1:0]);
    b = (m_ld >> (8 * off)) & 32'hFF;
    h = (m_ld >> (16 * (off / 2))) & 32'hFFFF;
    if (!m_mtr)          return m_alu;
    if (m_op == OP_LB)   return (b > 32'd127) ? b + 32'hFFFF_FF00 : b;
    if (m_op == OP_LBU)  return b;
    if (m_op == OP_LH)   return (h > 32'd32767) ? h + 32'hFFFF_0000 : h;
    if (m_op == OP_LHU)  return h;
    return m_ld;
  endfunction

  function automatic bit exp_misaligned();
    int unsigned off;
    off = int'(m_alu[1:0]);
    if (!(m_mtr && m_ce)) return 1'b0;
    if (m_op == OP_LW) return off != 0;
    if (m_op == OP_LH || m_op == OP_LHU) return (off % 2) == 1;
    return 1'b0;
  endfunction

  function automatic bit exp_wr();
    return m_ce && m_rw && (m_rd != 5'd0) && !m_wr_done && !exp_misaligned();
  endfunction

  function automatic bit exp_mis();
    return exp_misaligned() && !m_mis_done;
  endfunction

  task automatic model_reset();
    m_ce = 0; m_mtr = 0; m_rw = 0; m_alu = 0; m_ld = 0; m_rd = 0; m_op = 0;
    m_wr_done = 0; m_mis_done = 0; m_ret = 0;
  endtask

  // Advance the model across one clock edge using the inputs the DUT sampled.
  task automatic model_update();
    bit wr_now, mis_now;
    wr_now  = exp_wr();
    mis_now = exp_mis();
    if (m_ce && !stall && !flush) m_ret = m_ret + 32'd1;
    if (flush) begin
      m_ce = 0; m_wr_done = 0; m_mis_done = 0;
    end else if (!stall) begin
      m_ce = ce; m_mtr = mtr; m_rw = rw; m_alu = alu; m_ld = ld; m_rd = rd; m_op = op;
      m_wr_done = 0; m_mis_done = 0;
    end else begin
      m_wr_done  = m_wr_done | wr_now;
      m_mis_done = m_mis_done | mis_now;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic check_all();
    chk("ce",       32'(o_ce),  32'(m_ce));
    chk("reg_wr",   32'(o_wr),  32'(exp_wr()));
    chk("rd_addr",  32'(o_rd),  32'(m_rd));
    chk("data",     o_data,     exp_data());
    chk("misalign", 32'(o_mis), 32'(exp_mis()));
`ifdef WB_RETIRE_CNT_EN
    chk("retired",  o_ret,      m_ret);
`endif
  endtask

  // One cycle: drive inputs after the falling edge, step model at the rising edge, check at the next falling edge.
  task automatic cyc(input logic i_ce, input logic i_stall, input logic i_flush,
                     input logic i_mtr, input logic i_rw, input logic [31:0] i_alu,
                     input logic [31:0] i_ld, input logic [4:0] i_rd, input logic [OW-1:0] i_op);
    ce = i_ce; stall = i_stall; flush = i_flush; mtr = i_mtr; rw = i_rw;
    alu = i_alu; ld = i_ld; rd = i_rd; op = i_op;
    @(posedge wb_clk);
    model_update();
    @(negedge wb_clk);
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, OW'(0));
  endtask

  logic [OW-1:0] ops [7];
  int            pulses;
  logic [31:0]   ret_base;

  initial begin
    ops[0] = OP_LB; ops[1] = OP_LH; ops[2] = OP_LW; ops[3] = OP_LBU;
    ops[4] = OP_LHU; ops[5] = OW'(0); ops[6] = OW'(8'h2B);
    pulses = 0; ret_base = 0;
    wb_rst = 1'b1;
    ce = 0; stall = 0; flush = 0; mtr = 0; rw = 0; alu = 0; ld = 0; rd = 0; op = 0;
    model_reset();
    @(negedge wb_clk);
    chk("rst_ce",   32'(o_ce),  32'd0);
    chk("rst_wr",   32'(o_wr),  32'd0);
    chk("rst_data", o_data,     32'd0);
    check_all();
    wb_rst = 1'b0;
    @(negedge wb_clk);

    // ALU write
    cyc(1, 0, 0, 0, 1, 32'h0000_1234, 32'hDEAD_BEEF, 5'd5, OW'(0));
    chk("alu_wr",   32'(o_wr),  32'd1);
    chk("alu_rd",   32'(o_rd),  32'd5);
    chk("alu_data", o_data,     32'h0000_1234);

    // Load extension cases
    cyc(1, 0, 0, 1, 1, 32'h0000_0003, 32'h80FF_7F01, 5'd7, OP_LB);
    chk("lb_off3",  o_data, 32'hFFFF_FF80);
    cyc(1, 0, 0, 1, 1, 32'h0000_0002, 32'h80FF_7F01, 5'd7, OP_LBU);
    chk("lbu_off2", o_data, 32'h0000_00FF);
    cyc(1, 0, 0, 1, 1, 32'h0000_0002, 32'h80FF_7F01, 5'd7, OP_LH);
    chk("lh_off2",  o_data, 32'hFFFF_80FF);
    cyc(1, 0, 0, 1, 1, 32'h0000_0000, 32'h80FF_7F01, 5'd7, OP_LHU);
    chk("lhu_off0", o_data, 32'h0000_7F01);

    // Stall for 3 cycles after capture: exactly one write pulse, data stable
    cyc(1, 0, 0, 0, 1, 32'h0000_CAFE, 32'd0, 5'd9, OW'(0));
    pulses = int'(o_wr);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 0, 32'h1111_1111, 32'd0, 5'd3, OW'(0));
      pulses += int'(o_wr);
      chk("stall_data", o_data, 32'h0000_CAFE);
    end
    chk("stall_pulses", 32'(pulses), 32'd1);
    idle();

    // Flush during stall
    cyc(1, 0, 0, 0, 1, 32'h0000_0042, 32'd0, 5'd4, OW'(0));
    cyc(1, 1, 1, 0, 1, 32'h0000_0099, 32'd0, 5'd6, OW'(0));
    chk("flush_ce", 32'(o_ce), 32'd0);
    chk("flush_wr", 32'(o_wr), 32'd0);

    // rd=0 then misaligned LW
`ifdef WB_RETIRE_CNT_EN
    ret_base = o_ret;
`endif
    cyc(1, 0, 0, 0, 1, 32'h0000_0077, 32'd0, 5'd0, OW'(0));
    chk("rd0_wr", 32'(o_wr), 32'd0);
    cyc(1, 0, 0, 1, 1, 32'h0000_0002, 32'h1234_5678, 5'd8, OP_LW);
    chk("lw_mis", 32'(o_mis), 32'd1);
    chk("lw_wr",  32'(o_wr),  32'd0);
    idle();
    chk("mis_clear", 32'(o_mis), 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("retired_plus2", o_ret - ret_base, 32'd2);
`endif

    // Misaligned load held under stall: one misalign pulse only
    cyc(1, 0, 0, 1, 1, 32'h0000_0001, 32'h0, 5'd8, OP_LH);
    pulses = int'(o_mis);
    cyc(0, 1, 0, 0, 0, 32'd0, 32'd0, 5'd0, OW'(0));
    pulses += int'(o_mis);
    cyc(0, 1, 0, 0, 0, 32'd0, 32'd0, 5'd0, OW'(0));
    pulses += int'(o_mis);
    chk("mis_once", 32'(pulses), 32'd1);
    idle();

    // Reset mid-stall with a valid instruction held
    cyc(1, 0, 0, 0, 1, 32'h0000_0055, 32'd0, 5'd3, OW'(0));
    stall = 1'b1;
    wb_rst = 1'b1;
    #1;
    chk("midrst_ce",   32'(o_ce),  32'd0);
    chk("midrst_wr",   32'(o_wr),  32'd0);
    chk("midrst_rd",   32'(o_rd),  32'd0);
    chk("midrst_data", o_data,     32'd0);
    chk("midrst_mis",  32'(o_mis), 32'd0);
    model_reset();
    @(posedge wb_clk);
    @(negedge wb_clk);
    wb_rst = 1'b0;
    stall = 1'b0;
    check_all();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 9) < 3),
          1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) != 0),
          $urandom,
          $urandom,
          5'($urandom_range(0, 31)),
          ops[$urandom_range(0, 6)]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
